// File: rtl/sd_test_pkg.sv
// Shared definitions for the SD burst test sequencer: FSM state encoding,
// run modes, command/status byte codes and the test pattern generator.
package sd_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_DATA,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_NEXT,
    ST_REPORT
  } seq_state_t;

  typedef enum logic [1:0] {
    MODE_WRITE,
    MODE_READ,
    MODE_VERIFY
  } run_mode_t;

  localparam logic [7:0] CMD_WRITE  = 8'h7A;  // "z"
  localparam logic [7:0] CMD_READ   = 8'h6F;  // "o"
  localparam logic [7:0] CMD_VERIFY = 8'h76;  // "v"
  localparam logic [7:0] CMD_ABORT  = 8'h73;  // "s"
  localparam logic [7:0] STAT_OK    = 8'h4B;  // "K"
  localparam logic [7:0] STAT_ERR   = 8'h45;  // "E"
  localparam logic [7:0] STAT_ABORT = 8'h53;  // "S"

  function automatic logic is_run_cmd(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ) || (cmd == CMD_VERIFY);
  endfunction

  // Byte n of a run carries seed + n, wrapping modulo 256.
  function automatic logic [7:0] pattern_byte(input logic [7:0] seed, input logic [7:0] idx);
    return seed + idx;
  endfunction

endpackage

// File: rtl/sd_burst_sequencer_if.sv
// Signal bundle between the burst sequencer, the UART command/status path
// and card_driver. master = sequencer side, slave = environment side.
interface sd_burst_sequencer_if #(parameter int ADDR_W = 32);
  // Handshakes: wr_stb/rd_stb/wd_stb are level requests held until the
  // matching *_ack is sampled high on a clock edge; that edge completes the
  // transfer. cmd_stb and res_stb are single-cycle pushes with no back-pressure
  // (res_busy is always 0). stat_stb pulses for one cycle only while stat_rdy.
  logic              cmd_stb;
  logic [7:0]        cmd_dat;
  logic              wr_stb;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] wr_length;
  logic              wr_ack;
  logic              wd_stb;
  logic [7:0]        wd_data;
  logic              wd_ack;
  logic              rd_stb;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_length;
  logic              rd_ack;
  logic              res_stb;
  logic [7:0]        res_data;
  logic              res_busy;
  logic              stat_stb;
  logic [7:0]        stat_dat;
  logic              stat_rdy;
  logic              running;

  modport master (
    input  cmd_stb, cmd_dat, wr_ack, wd_ack, rd_ack, res_stb, res_data, stat_rdy,
    output wr_stb, wr_addr, wr_length, wd_stb, wd_data, rd_stb, rd_addr, rd_length,
           res_busy, stat_stb, stat_dat, running
  );

  modport slave (
    output cmd_stb, cmd_dat, wr_ack, wd_ack, rd_ack, res_stb, res_data, stat_rdy,
    input  wr_stb, wr_addr, wr_length, wd_stb, wd_data, rd_stb, rd_addr, rd_length,
           res_busy, stat_stb, stat_dat, running
  );
endinterface

// File: rtl/sd_pattern_checker.sv
// Expected-pattern generator and read-back comparator with sticky error flag.
// SD_SEQ_ERRCNT_EN adds a 32-bit saturating mismatch counter.
module sd_pattern_checker
  import sd_test_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h41
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       check,
  input  logic [7:0] idx,
  input  logic [7:0] data,
  output logic [7:0] exp_byte,
  output logic       err_flag
`ifdef SD_SEQ_ERRCNT_EN
  ,
  output logic [31:0] err_cnt
`endif
);

  logic mismatch;

  assign exp_byte = pattern_byte(SEED, idx);
  assign mismatch = check && (data != exp_byte);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_flag <= 1'b0;
    end else if (mismatch) begin
      err_flag <= 1'b1;
    end
  end

`ifdef SD_SEQ_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: rtl/sd_burst_sequencer.sv
// SD-card burst test sequencer: write / read / write-then-verify runs over
// consecutive card addresses, reporting a status byte. Option: SD_SEQ_ERRCNT_EN.
module sd_burst_sequencer
  import sd_test_pkg::*;
#(
  parameter int         BURST_SIZE  = 10000,
  parameter int         BURST_COUNT = 16,
  parameter int         ADDR_W      = 32,
  parameter logic [7:0] SEED        = 8'h41
) (
  input  logic                 clk,
  input  logic                 rst,
  sd_burst_sequencer_if.master bus,
  output seq_state_t           state
);

  localparam int                  BYTE_W     = $clog2(BURST_SIZE + 1);
  localparam int                  BURST_W    = $clog2(BURST_COUNT + 1);
  localparam logic [BYTE_W-1:0]   LAST_BYTE  = BYTE_W'(BURST_SIZE - 1);
  localparam logic [BURST_W-1:0]  LAST_BURST = BURST_W'(BURST_COUNT - 1);
  localparam logic [ADDR_W-1:0]   ADDR_STEP  = ADDR_W'(BURST_SIZE);
  localparam logic [7:0]          IDX_STEP   = 8'(BURST_SIZE);
`ifdef SD_SEQ_ERRCNT_EN
  localparam logic [2:0]          LAST_RPT   = 3'd4;
`else
  localparam logic [2:0]          LAST_RPT   = 3'd0;
`endif

  seq_state_t         state_q, state_d;
  run_mode_t          mode;
  logic [ADDR_W-1:0]  addr;
  logic [BURST_W-1:0] burst_cnt;
  logic [BYTE_W-1:0]  byte_cnt;
  logic [7:0]         base_idx;
  logic [7:0]         pat_idx;
  logic [2:0]         rpt_idx;
  logic               aborted;
  logic               abort, accept, run_clear, byte_last, burst_last;
  logic               wd_take, res_take, stat_send, err_flag;
  logic [7:0]         exp_byte, status, stat_byte;
`ifdef SD_SEQ_ERRCNT_EN
  logic [31:0]        err_cnt;
`endif

  // Abort wins over any acknowledge or read byte arriving on the same edge.
  assign abort      = bus.cmd_stb && (bus.cmd_dat == CMD_ABORT) &&
                      (state_q != ST_IDLE) && (state_q != ST_REPORT);
  assign accept     = (state_q == ST_IDLE) && bus.cmd_stb && is_run_cmd(bus.cmd_dat);
  assign run_clear  = (state_q == ST_IDLE);
  assign byte_last  = (byte_cnt == LAST_BYTE);
  assign burst_last = (burst_cnt == LAST_BURST);
  assign wd_take    = (state_q == ST_WR_DATA) && bus.wd_ack && !abort;
  assign res_take   = (state_q == ST_RD_DATA) && bus.res_stb && !abort;
  assign stat_send  = (state_q == ST_REPORT) && bus.stat_rdy;
  // Run byte index mod 256; a verify read-back reuses base_idx of its write burst.
  assign pat_idx    = base_idx + 8'(byte_cnt);

  sd_pattern_checker #(.SEED(SEED)) u_checker (
    .clk      (clk),
    .rst      (rst),
    .clear    (run_clear),
    .check    (res_take),
    .idx      (pat_idx),
    .data     (bus.res_data),
    .exp_byte (exp_byte),
    .err_flag (err_flag)
`ifdef SD_SEQ_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus.wr_stb   = 1'b0;
    bus.wd_stb   = 1'b0;
    bus.rd_stb   = 1'b0;
    bus.stat_stb = 1'b0;
    case (state_q)
      ST_IDLE:    if (accept) state_d = (bus.cmd_dat == CMD_READ) ? ST_RD_REQ : ST_WR_REQ;
      ST_WR_REQ: begin
        bus.wr_stb = 1'b1;
        if (bus.wr_ack) state_d = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        bus.wd_stb = 1'b1;
        if (wd_take && byte_last) state_d = (mode == MODE_VERIFY) ? ST_RD_REQ : ST_NEXT;
      end
      ST_RD_REQ: begin
        bus.rd_stb = 1'b1;
        if (bus.rd_ack) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: if (res_take && byte_last) state_d = ST_NEXT;
      ST_NEXT: begin
        if (burst_last)              state_d = ST_REPORT;
        else if (mode == MODE_READ)  state_d = ST_RD_REQ;
        else                         state_d = ST_WR_REQ;
      end
      ST_REPORT: begin
        bus.stat_stb = bus.stat_rdy;
        if (stat_send && (rpt_idx == LAST_RPT)) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_REPORT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode      <= MODE_WRITE;
      addr      <= '0;
      burst_cnt <= '0;
      byte_cnt  <= '0;
      base_idx  <= '0;
      rpt_idx   <= '0;
      aborted   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        addr      <= '0;
        burst_cnt <= '0;
        byte_cnt  <= '0;
        base_idx  <= '0;
        rpt_idx   <= '0;
        aborted   <= 1'b0;
        if (accept) begin
          if (bus.cmd_dat == CMD_READ)        mode <= MODE_READ;
          else if (bus.cmd_dat == CMD_VERIFY) mode <= MODE_VERIFY;
          else                                mode <= MODE_WRITE;
        end
      end
      if (abort) aborted <= 1'b1;
      if (wd_take || res_take) byte_cnt <= byte_last ? '0 : byte_cnt + BYTE_W'(1);
      if (state_q == ST_NEXT) begin
        addr      <= addr + ADDR_STEP;
        burst_cnt <= burst_cnt + BURST_W'(1);
        base_idx  <= base_idx + IDX_STEP;
      end
      if (stat_send) rpt_idx <= rpt_idx + 3'd1;
    end
  end

  always_comb begin
    status = STAT_OK;
    if (aborted)       status = STAT_ABORT;
    else if (err_flag) status = STAT_ERR;
  end

`ifdef SD_SEQ_ERRCNT_EN
  // Status byte first, then the mismatch count most significant byte first.
  always_comb begin
    case (rpt_idx)
      3'd0:    stat_byte = status;
      3'd1:    stat_byte = err_cnt[31:24];
      3'd2:    stat_byte = err_cnt[23:16];
      3'd3:    stat_byte = err_cnt[15:8];
      default: stat_byte = err_cnt[7:0];
    endcase
  end
`else
  assign stat_byte = status;
`endif

  assign bus.wr_addr   = addr;
  assign bus.rd_addr   = addr;
  assign bus.wr_length = ADDR_W'(BURST_SIZE);
  assign bus.rd_length = ADDR_W'(BURST_SIZE);
  assign bus.wd_data   = exp_byte;
  assign bus.res_busy  = 1'b0;
  assign bus.stat_dat  = stat_byte;
  assign bus.running   = (state_q != ST_IDLE);
  assign state         = state_q;

endmodule

// File: tb/tb_sd_burst_sequencer.sv
// Bench for sd_burst_sequencer: table of whole runs against a card model,
// plus hand sequences for abort, stalled status and mid-run reset.
module tb_sd_burst_sequencer;
  import sd_test_pkg::*;

  localparam int         BS   = 4;
  localparam int         BC   = 2;
  localparam int         AW   = 32;
  localparam logic [7:0] SEED = 8'h41;
`ifdef SD_SEQ_ERRCNT_EN
  localparam int         N_STAT = 5;
`else
  localparam int         N_STAT = 1;
`endif

  typedef struct {
    logic [7:0]  cmd;
    int          corrupt;
    logic [7:0]  stat;
    int          n_wr;
    int          n_rd;
    logic [31:0] errs;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  seq_state_t state_dbg;

  always #5 clk = ~clk;

  sd_burst_sequencer_if #(.ADDR_W(AW)) bus ();

  sd_burst_sequencer #(
    .BURST_SIZE (BS),
    .BURST_COUNT(BC),
    .ADDR_W     (AW),
    .SEED       (SEED)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .state(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_wd_q[$];
  logic [7:0]  exp_stat_q[$];
  logic [31:0] exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- card / UART model ----------------
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] wr_base, rd_base;
  int   wr_wait, rd_wait, wd_off, rd_off, rd_left, run_res, wd_taken;
  int   wd_limit    = 1000000;
  int   corrupt_idx = -1;
  int   stat_seen   = 0;
  int   res_seen    = 0;
  logic res_hold    = 1'b0;
  logic stat_rdy_en = 1'b1;
  logic toggle      = 1'b0;

  initial begin : card_model
    bus.wr_ack = 1'b0; bus.wd_ack = 1'b0; bus.rd_ack = 1'b0;
    bus.res_stb = 1'b0; bus.res_data = 8'h00; bus.stat_rdy = 1'b0;
    wr_wait = 0; rd_wait = 0; wd_off = 0; rd_off = 0; rd_left = 0; run_res = 0; wd_taken = 0;
    wr_base = '0; rd_base = '0;
    forever begin
      @(negedge clk);
      bus.wr_ack = 1'b0; bus.wd_ack = 1'b0; bus.rd_ack = 1'b0;
      bus.res_stb = 1'b0; bus.res_data = 8'h00;
      bus.stat_rdy = stat_rdy_en;
      toggle = ~toggle;
      if (rst || !bus.running) begin
        wr_wait = 0; rd_wait = 0; rd_left = 0; run_res = 0; wd_taken = 0;
      end else begin
        if (bus.wr_stb) begin
          if (wr_wait == 2) begin
            bus.wr_ack = 1'b1; wr_wait = 0; wr_base = bus.wr_addr; wd_off = 0;
            if (exp_wr_q.size() == 0) check("wr_req_extra", 32'(exp_wr_q.size()), 1);
            else check("wr_addr", bus.wr_addr, exp_wr_q.pop_front());
            check("wr_length", bus.wr_length, BS);
          end else wr_wait++;
        end
        if (bus.wd_stb && toggle && (wd_taken < wd_limit)) begin
          bus.wd_ack = 1'b1;
          mem[wr_base + 32'(wd_off)] = bus.wd_data;
          wd_off++; wd_taken++;
          if (exp_wd_q.size() == 0) check("wd_extra", 32'(exp_wd_q.size()), 1);
          else check("wd_data", bus.wd_data, exp_wd_q.pop_front());
        end
        if (rd_left > 0) begin
          if (!res_hold) begin
            bus.res_stb  = 1'b1;
            bus.res_data = mem[rd_base + 32'(rd_off)];
            if (run_res == corrupt_idx) bus.res_data = bus.res_data ^ 8'hFF;
            rd_off++; rd_left--; run_res++; res_seen++;
          end
        end else if (bus.rd_stb) begin
          if (rd_wait == 1) begin
            bus.rd_ack = 1'b1; rd_wait = 0; rd_base = bus.rd_addr; rd_off = 0; rd_left = BS;
            if (exp_rd_q.size() == 0) check("rd_req_extra", 32'(exp_rd_q.size()), 1);
            else check("rd_addr", bus.rd_addr, exp_rd_q.pop_front());
            check("rd_length", bus.rd_length, BS);
          end else rd_wait++;
        end
      end
      #1;
      if (bus.stat_stb) begin
        stat_seen++;
        if (exp_stat_q.size() == 0) check("stat_extra", 32'(exp_stat_q.size()), 1);
        else check("stat_dat", bus.stat_dat, exp_stat_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk);
    bus.cmd_stb = 1'b1;
    bus.cmd_dat = c;
    @(negedge clk);
    bus.cmd_stb = 1'b0;
    bus.cmd_dat = 8'h00;
  endtask

  task automatic push_status(input logic [7:0] s, input logic [31:0] errs);
    exp_stat_q.push_back(s);
`ifdef SD_SEQ_ERRCNT_EN
    exp_stat_q.push_back(errs[31:24]);
    exp_stat_q.push_back(errs[23:16]);
    exp_stat_q.push_back(errs[15:8]);
    exp_stat_q.push_back(errs[7:0]);
`else
    if (errs != 0) exp_stat_q.push_back(s);
    if (errs != 0) void'(exp_stat_q.pop_back());
`endif
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (bus.running && (n < budget)) begin
      @(negedge clk); #2; n++;
    end
    check(name, bus.running, 0);
  endtask

  task automatic wait_state(input string name, input seq_state_t st, input int budget);
    int n = 0;
    while ((state_dbg != st) && (n < budget)) begin
      @(negedge clk); #2; n++;
    end
    check(name, 32'(state_dbg), 32'(st));
  endtask

  task automatic check_drained();
    check("wd_q_left",   32'(exp_wd_q.size()), 0);
    check("stat_q_left", 32'(exp_stat_q.size()), 0);
    check("wr_q_left",   32'(exp_wr_q.size()), 0);
    check("rd_q_left",   32'(exp_rd_q.size()), 0);
  endtask

  task automatic push_run(input int n_wr, input int n_rd);
    for (int b = 0; b < n_wr; b++) begin
      exp_wr_q.push_back(32'(b * BS));
      for (int i = 0; i < BS; i++) exp_wd_q.push_back(SEED + 8'(b * BS + i));
    end
    for (int b = 0; b < n_rd; b++) exp_rd_q.push_back(32'(b * BS));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},   32'(state_dbg), 32'(ST_IDLE));
    check({tag, "_running"}, bus.running, 0);
    check({tag, "_wr_stb"},  bus.wr_stb, 0);
    check({tag, "_wd_stb"},  bus.wd_stb, 0);
    check({tag, "_rd_stb"},  bus.rd_stb, 0);
    check({tag, "_stat_stb"}, bus.stat_stb, 0);
    check({tag, "_wr_addr"}, bus.wr_addr, 0);
    check({tag, "_rd_addr"}, bus.rd_addr, 0);
    check({tag, "_wr_len"},  bus.wr_length, BS);
    check({tag, "_rd_len"},  bus.rd_length, BS);
    check({tag, "_wd_data"}, bus.wd_data, 8'h41);
    check({tag, "_res_busy"}, bus.res_busy, 0);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs [4];

  initial begin : main
    int st0, res0, hi_cnt;
    bus.cmd_stb = 1'b0;
    bus.cmd_dat = 8'h00;

    vecs[0] = '{CMD_WRITE,  -1, STAT_OK,  2, 0, 32'd0};
    vecs[1] = '{CMD_VERIFY, -1, STAT_OK,  2, 2, 32'd0};
    vecs[2] = '{CMD_READ,   -1, STAT_OK,  0, 2, 32'd0};
    vecs[3] = '{CMD_VERIFY,  6, STAT_ERR, 2, 2, 32'd1};

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Non-run commands in IDLE, including abort, are ignored.
    send_cmd(8'h58);
    #1;
    check("idle_ignore_x", bus.running, 0);
    send_cmd(CMD_ABORT);
    #1;
    check("idle_ignore_s", 32'(state_dbg), 32'(ST_IDLE));

    for (int v = 0; v < 4; v++) begin
      st0 = stat_seen;
      res0 = res_seen;
      corrupt_idx = vecs[v].corrupt;
      push_run(vecs[v].n_wr, vecs[v].n_rd);
      push_status(vecs[v].stat, vecs[v].errs);
      send_cmd(vecs[v].cmd);
      #1;
      check("run_started", bus.running, 1);
      wait_idle("run_done", 400);
      check("res_count", 32'(res_seen - res0), 32'(vecs[v].n_rd * BS));
      check("stat_count", 32'(stat_seen - st0), N_STAT);
      check_drained();
      corrupt_idx = -1;
    end

    // Abort during WR_DATA after two accepted bytes.
    wd_limit = 2;
    exp_wr_q.push_back(32'd0);
    exp_wd_q.push_back(8'h41);
    exp_wd_q.push_back(8'h42);
    push_status(STAT_ABORT, 32'd0);
    send_cmd(CMD_WRITE);
    begin
      int n = 0;
      while ((wd_taken < 2) && (n < 100)) begin @(negedge clk); #2; n++; end
    end
    check("abort_acks_seen", 32'(wd_taken), 2);
    @(negedge clk);
    #1;
    check("abort_pre_wd_stb", bus.wd_stb, 1);
    check("abort_pre_wd_data", bus.wd_data, 8'h43);
    send_cmd(CMD_ABORT);
    #1;
    check("abort_wd_stb", bus.wd_stb, 0);
    check("abort_state", 32'(state_dbg), 32'(ST_REPORT));
    wait_idle("abort_done", 50);
    check_drained();
    wd_limit = 1000000;

    // Status held off by STAT_RDY low for 50 cycles.
    stat_rdy_en = 1'b0;
    push_run(2, 0);
    push_status(STAT_OK, 32'd0);
    st0 = stat_seen;
    send_cmd(CMD_WRITE);
    wait_state("stall_reach_report", ST_REPORT, 200);
    hi_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (bus.stat_stb) hi_cnt++;
    end
    check("stall_no_stb", 32'(hi_cnt), 0);
    check("stall_state", 32'(state_dbg), 32'(ST_REPORT));
    stat_rdy_en = 1'b1;
    wait_idle("stall_done", 50);
    check("stall_stat_count", 32'(stat_seen - st0), N_STAT);
    check_drained();

    // Reset in the middle of RD_DATA, with stray commands ignored beforehand.
    res_hold = 1'b1;
    exp_rd_q.push_back(32'd0);
    st0 = stat_seen;
    send_cmd(CMD_READ);
    wait_state("rst_reach_rd_data", ST_RD_DATA, 50);
    send_cmd(CMD_WRITE);
    send_cmd(CMD_READ);
    #1;
    check("midrun_cmd_state", 32'(state_dbg), 32'(ST_RD_DATA));
    check("midrun_cmd_wr_stb", bus.wr_stb, 0);
    check("midrun_cmd_running", bus.running, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    res_hold = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    check("midrun_rst_no_stat", 32'(stat_seen - st0), 0);
    check("midrun_rst_idle", 32'(state_dbg), 32'(ST_IDLE));
    check_drained();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
